// File: rtl/bcd_cnt_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bcd_cnt_ctrl
// Sequencer for an NDIGITS-wide decimal event counter. Increments arrive over
// a req/ack handshake and the carry ripples serially, one BCD digit per clock.
// The displayed count only changes when an increment commits (or when freeze
// is released), so partial ripple values are never visible.
//
// Optional feature: define BCD_SCAN_EN to build the display-scan divider and
// one-hot digit select. Without it scan_sel/scan_val are tied to zero.
//
// Ports:
//   clk       in   system clock, posedge
//   reset     in   asynchronous active-low reset
//   inc_req   in   increment request (level, held until inc_ack)
//   inc_ack   out  one-cycle pulse when the increment has committed
//   clr       in   synchronous clear (highest priority after reset)
//   freeze    in   1 = hold count (and scan path) at the last shown value
//   busy      out  1 while in RIPPLE or ACK
//   count     out  BCD value, digit 0 in bits [3:0]
//   overflow  out  sticky, set on wrap 99..9 -> 00..0
//   scan_sel  out  one-hot display digit select
//   scan_val  out  BCD value of the selected digit
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for inc_req
// RIPPLE | adding one to digit[idx]; on 9 -> 0 carry moves to idx+1
// ACK    | increment committed, inc_ack high, count loads unless frozen
// -----------------------------------------------------------------------------
module bcd_cnt_ctrl #(
    parameter int NDIGITS  = 4,
    parameter int SCAN_DIV = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc_req,
    output logic                   inc_ack,
    input  logic                   clr,
    input  logic                   freeze,
    output logic                   busy,
    output logic [4*NDIGITS-1:0]   count,
    output logic                   overflow,
    output logic [NDIGITS-1:0]     scan_sel,
    output logic [3:0]             scan_val
);

    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    if (NDIGITS < 1 || NDIGITS > 8 || SCAN_DIV < 2) begin : g_bad_param
        $error("bcd_cnt_ctrl: NDIGITS must be 1..8 and SCAN_DIV >= 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RIPPLE = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t               state;
    logic [IDXW-1:0]      idx;
    logic [3:0]           dig [NDIGITS];
    logic [4*NDIGITS-1:0] dig_flat;
    logic                 freeze_q;

    always_comb begin
        dig_flat = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            dig_flat[4*i +: 4] = dig[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            for (int i = 0; i < NDIGITS; i++) begin
                dig[i] <= 4'd0;
            end
            count    <= '0;
            overflow <= 1'b0;
            inc_ack  <= 1'b0;
            busy     <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            freeze_q <= freeze;
            if (clr) begin
                state    <= IDLE;
                idx      <= '0;
                for (int i = 0; i < NDIGITS; i++) begin
                    dig[i] <= 4'd0;
                end
                count    <= '0;
                overflow <= 1'b0;
                inc_ack  <= 1'b0;
                busy     <= 1'b0;
            end else begin
                // Digits are only consistent outside RIPPLE, so a freeze
                // release during a ripple waits for the ACK load instead.
                if (!freeze && (state == ACK || (freeze_q && state != RIPPLE))) begin
                    count <= dig_flat;
                end

                case (state)
                    IDLE: begin
                        inc_ack <= 1'b0;
                        idx     <= '0;
                        if (inc_req) begin
                            state <= RIPPLE;
                            busy  <= 1'b1;
                        end else begin
                            busy  <= 1'b0;
                        end
                    end
                    RIPPLE: begin
                        if (dig[idx] != 4'd9) begin
                            dig[idx] <= dig[idx] + 4'd1;
                            state    <= ACK;
                            inc_ack  <= 1'b1;
                        end else begin
                            dig[idx] <= 4'd0;
                            if (idx == LAST_IDX) begin
                                overflow <= 1'b1;
                                state    <= ACK;
                                inc_ack  <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    ACK: begin
                        inc_ack <= 1'b0;
                        busy    <= 1'b0;
                        idx     <= '0;
                        state   <= IDLE;
                    end
                    default: begin
                        inc_ack <= 1'b0;
                        busy    <= 1'b0;
                        idx     <= '0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef BCD_SCAN_EN
    localparam int DIVW = $clog2(SCAN_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);

    logic [DIVW-1:0] scan_div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_div <= '0;
            scan_sel <= NDIGITS'(1);
        end else if (scan_div == DIV_LAST) begin
            scan_div <= '0;
            // Rotate left; the right shift brings the top digit back to 0.
            scan_sel <= (scan_sel << 1) | (scan_sel >> (NDIGITS - 1));
        end else begin
            scan_div <= scan_div + 1'b1;
        end
    end

    always_comb begin
        scan_val = 4'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (scan_sel[i]) begin
                scan_val = scan_val | count[4*i +: 4];
            end
        end
    end
`else
    assign scan_sel = '0;
    assign scan_val = 4'd0;
`endif

endmodule

// File: tb/tb_bcd_cnt_ctrl.sv
`timescale 1ns/1ps
module tb_bcd_cnt_ctrl;

    localparam int N    = 4;
    localparam int MAXV = 9999;

    logic          clk = 1'b0;
    logic          reset;
    logic          inc_req;
    logic          inc_ack;
    logic          clr;
    logic          freeze;
    logic          busy;
    logic [15:0]   count;
    logic          overflow;
    logic [3:0]    scan_sel;
    logic [3:0]    scan_val;

    bcd_cnt_ctrl #(.NDIGITS(N), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .inc_req(inc_req), .inc_ack(inc_ack),
        .clr(clr), .freeze(freeze), .busy(busy), .count(count),
        .overflow(overflow), .scan_sel(scan_sel), .scan_val(scan_val)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: plain decimal value plus what the display should show.
    int unsigned val;
    bit          m_ovf;
    logic [15:0] shown;

    typedef struct {
        bit          clr_first;
        bit          fz;
        int          n_inc;
        logic [15:0] exp_count;
        bit          exp_ovf;
    } vec_t;

    vec_t tbl [8];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(int unsigned v);
        logic [15:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digits touched = trailing nines + 1 (capped at N); ack one cycle later.
    function automatic int exp_lat(int unsigned v);
        int k;
        int unsigned x;
        k = 1;
        x = v;
        while ((x % 10) == 9 && k < N) begin
            k++;
            x = x / 10;
        end
        return k + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_inc();
        int lat;
        int want;
        lat  = -1;
        want = exp_lat(val);
        inc_req = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (inc_ack) begin
                lat = n;
                break;
            end
        end
        inc_req = 1'b0;
        check("inc_latency", lat, want);
        if (lat > 0) check("busy_at_ack", {31'd0, busy}, 32'd1);
        if (val == MAXV) begin
            val   = 0;
            m_ovf = 1'b1;
        end else begin
            val++;
        end
        if (!freeze) shown = to_bcd(val);
        tick();
        check("ack_one_cycle", {31'd0, inc_ack}, 32'd0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr   = 1'b0;
        val   = 0;
        m_ovf = 1'b0;
        shown = '0;
        check("clr_count", count, 0);
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  prev_sel;
        bit          synced;
        logic [15:0] ref_bcd;
        bit          new_fz;

        tbl[0] = '{1'b1, 1'b0, 7,    16'h0007, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 192,  16'h0199, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1,    16'h0200, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 9799, 16'h9999, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1,    16'h0000, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 5,    16'h0005, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 42,   16'h0042, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 3,    16'h0042, 1'b0};

        reset   = 1'b0;
        inc_req = 1'b0;
        clr     = 1'b0;
        freeze  = 1'b0;
        val     = 0;
        m_ovf   = 1'b0;
        shown   = '0;

        #12;
        check("rst_count", count, 0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_ack", {31'd0, inc_ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef BCD_SCAN_EN
        check("rst_scan_sel", {28'd0, scan_sel}, 32'd1);
`else
        check("rst_scan_sel", {28'd0, scan_sel}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Table-driven walk through the main counting scenarios.
        for (int r = 0; r < 8; r++) begin
            if (tbl[r].clr_first) pulse_clr();
            freeze = tbl[r].fz;
            for (int i = 0; i < tbl[r].n_inc; i++) run_inc();
            check($sformatf("row%0d_count", r), count, tbl[r].exp_count);
            check($sformatf("row%0d_model", r), count, shown);
            check($sformatf("row%0d_ovf", r), {31'd0, overflow}, {31'd0, tbl[r].exp_ovf});
        end

        // Freeze release: count picks up the hidden increments next cycle.
        freeze = 1'b0;
        tick();
        shown = to_bcd(val);
        check("freeze_release", count, 16'h0045);

        // clr in the middle of a ripple from 0999 with inc_req held.
        pulse_clr();
        for (int i = 0; i < 999; i++) run_inc();
        check("pre_clr_count", count, 16'h0999);
        inc_req = 1'b1;
        tick();
        tick();
        check("ripple_busy", {31'd0, busy}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        val = 0;
        m_ovf = 1'b0;
        shown = '0;
        check("clr_mid_ack", {31'd0, inc_ack}, 32'd0);
        check("clr_mid_count", count, 0);
        check("clr_mid_busy", {31'd0, busy}, 32'd0);
        run_inc();
        check("after_clr_count", count, 16'h0001);

        // Reset asserted mid-ripple from 0009.
        for (int i = 0; i < 8; i++) run_inc();
        check("pre_rst_count", count, 16'h0009);
        inc_req = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_count", count, 0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_ack", {31'd0, inc_ack}, 32'd0);
        inc_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        val = 0;
        m_ovf = 1'b0;
        shown = '0;
        tick();
        run_inc();
        check("after_rst_count", count, 16'h0001);

        // Randomized increments, clears and freeze toggles against the model.
        for (int it = 0; it < 300; it++) begin
            new_fz = ($urandom_range(0, 3) == 0);
            if (freeze && !new_fz) begin
                freeze = 1'b0;
                tick();
                shown = to_bcd(val);
                check("rnd_freeze_release", count, shown);
            end else begin
                freeze = new_fz;
            end
            if ($urandom_range(0, 9) == 0) begin
                pulse_clr();
            end else begin
                run_inc();
            end
            check("rnd_count", count, shown);
            check("rnd_ovf", {31'd0, overflow}, {31'd0, m_ovf});
        end
        if (freeze) begin
            freeze = 1'b0;
            tick();
            shown = to_bcd(val);
            check("rnd_final_release", count, shown);
        end

`ifdef BCD_SCAN_EN
        pulse_clr();
        for (int i = 0; i < 1234; i++) run_inc();
        check("scan_preload", count, 16'h1234);
        ref_bcd = to_bcd(1234);
        synced = 1'b0;
        for (int n = 0; n < 40; n++) begin
            prev_sel = scan_sel;
            tick();
            if (scan_sel == 4'b0001 && prev_sel != 4'b0001) begin
                synced = 1'b1;
                break;
            end
        end
        check("scan_sync", {31'd0, synced}, 32'd1);
        for (int s = 0; s < 5; s++) begin
            check("scan_sel", {28'd0, scan_sel}, 32'd1 << (s % 4));
            check("scan_val", {28'd0, scan_val}, {28'd0, ref_bcd[4*(s%4) +: 4]});
            tick();
            tick();
            check("scan_hold", {28'd0, scan_sel}, 32'd1 << (s % 4));
            tick();
            tick();
        end
`else
        check("scan_sel_off", {28'd0, scan_sel}, 32'd0);
        check("scan_val_off", {28'd0, scan_val}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_cnt_ctrl.md
Name: bcd_cnt_ctrl

Overview:
Sequencer for an NDIGITS-wide decimal event counter built from per-digit BCD cells (digit value 0..9, carry out on 9->0).
- Accepts increment requests over a req/ack handshake and ripples the carry serially, one digit per clock, instead of a combinational carry chain.
- Provides a freezable snapshot output, sticky overflow and synchronous clear.
- Sits between event sources (button debouncers, CPU strobes) and the 7-segment display path.

Parameters:
NDIGITS, 4, number of BCD digits; legal range 1..8
SCAN_DIV, 16, clk cycles per display-scan step (BCD_SCAN_EN only); legal range >= 2

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
inc_req  in  1  increment request, level; held until inc_ack
inc_ack  out  1  one-cycle pulse; increment committed
clr  in  1  synchronous clear, highest priority after reset
freeze  in  1  1 = hold count output at the last committed value
busy  out  1  1 while in RIPPLE or ACK
count  out  4*NDIGITS  BCD value; digit 0 in bits [3:0]
overflow  out  1  sticky; set on wrap 99..9 -> 00..0
scan_sel  out  NDIGITS  one-hot display digit select
scan_val  out  4  BCD value of the selected digit

Behaviour:
- Reset (reset=0, async):
  - internal digits = 0, count = 0, overflow = 0, inc_ack = 0, busy = 0
  - state = IDLE, idx = 0
  - scan_sel = 1 (digit 0), scan divider = 0
- FSM states: IDLE, RIPPLE, ACK.
- IDLE:
  - inc_req=1 -> RIPPLE with idx=0.
  - Otherwise stay in IDLE.
- RIPPLE (one digit per cycle):
  - digit[idx] != 9: digit[idx] += 1, go to ACK.
  - digit[idx] == 9: digit[idx] = 0.
    - If idx < NDIGITS-1: idx += 1, stay in RIPPLE.
    - If idx == NDIGITS-1: set overflow = 1, go to ACK.
- ACK:
  - inc_ack = 1 for exactly this cycle.
  - Committed value is copied to count unless freeze = 1.
  - Next state IDLE, idx = 0.
- Latency: an increment touching k digits (k-1 trailing 9s) gives inc_ack k+1 cycles after the first IDLE cycle with inc_req=1. Worst case is NDIGITS+1 cycles.
- Handshake rules:
  - Requester drops inc_req on the cycle it samples inc_ack.
  - If inc_req is still 1 in the IDLE cycle after ACK, it counts as a new request.
  - Changes on inc_req while busy=1 are ignored.
- Intermediate ripple values are never visible on count; count changes only on the ACK cycle.
- clr=1 (any state):
  - next cycle digits = 0, count = 0, overflow = 0, state = IDLE, inc_ack = 0
  - An interrupted increment is dropped and not acked; a held inc_req is served afresh after clr falls.
- freeze=1:
  - count and the scan path hold their value.
  - Increments still commit internally.
  - On freeze 1->0, count loads the internal value on the next cycle.
- Reset asserted mid-RIPPLE: immediate return to the reset state; no partial value is retained.
- busy = 1 in RIPPLE or ACK.

Optional Feature:
- Macro BCD_SCAN_EN.
- Defined:
  - Divider counts 0..SCAN_DIV-1.
  - On terminal count, scan_sel rotates left by one, wrapping from digit NDIGITS-1 back to digit 0.
  - scan_val = the count digit selected by scan_sel, combinational from registered state.
  - Scan runs regardless of clr and freeze.
- Not defined:
  - scan_sel = 0 and scan_val = 0 constant.
  - No divider logic is generated.

Test Plan:
- Reset, then 7 single increments with NDIGITS=4 -> count=0x0007, each inc_ack 2 cycles after request, overflow=0.
- Preload to 0x0199 via increments, one more request -> RIPPLE lasts 3 cycles, inc_ack 4 cycles after request, count=0x0200.
- From 0x9999, one request -> inc_ack after 5 cycles, count=0x0000, overflow=1; overflow stays 1 across further increments until clr.
- freeze=1 at 0x0042, 3 increments -> count stays 0x0042; release freeze -> count=0x0045 next cycle.
- clr during RIPPLE from 0x0999 with inc_req held -> no inc_ack, count=0x0000; after clr falls, request is served -> count=0x0001.
- BCD_SCAN_EN, SCAN_DIV=4, count=0x1234 -> scan_sel goes 0001,0010,0100,1000,0001 every 4 cycles, with scan_val 4,3,2,1,4.
